// File: rtl/klein_dec_sched.sv
// rtl/klein_dec_sched.sv - block sequencer for one klein_decipher core (ECB; CBC when KLEIN_DEC_SCHED_CBC_EN is defined)
module klein_dec_sched #(
    parameter int TIMEOUT_CYC = 32,
    parameter int CNT_W       = 16
) (
    input  logic             iclk,
    input  logic             ireset,
    input  logic             ikey_we,
    input  logic [63:0]      ikey,
    input  logic             iiv_we,
    input  logic [63:0]      iiv,
    input  logic             iin_valid,
    input  logic [63:0]      iin_block,
    output logic             oin_ready,
    output logic             oout_valid,
    output logic [63:0]      oout_block,
    input  logic             iout_ready,
    output logic             ocore_start,
    output logic [63:0]      ocore_block,
    output logic [63:0]      ocore_key,
    input  logic             icore_ready,
    input  logic [63:0]      icore_block,
    output logic             obusy,
    output logic             oerr,
    output logic [CNT_W-1:0] ocount
);

    localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        OUT   = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t           state_q;
    logic [63:0]      key_q;
    logic [63:0]      cblk_q;
    logic [63:0]      core_key_q;
    logic [63:0]      out_block_q;
    logic             out_valid_q;
    logic             core_start_q;
    logic             err_q;
    logic [CNT_W-1:0] count_q;
    logic [WD_W-1:0]  wd_q;
    logic [63:0]      key_d;
    logic [63:0]      pt_d;

`ifdef KLEIN_DEC_SCHED_CBC_EN
    logic [63:0]      chain_q;
`else
    logic             unused_ecb;
    assign unused_ecb = ^{iiv_we, iiv};
`endif

    // A key written on the same cycle as an accept is the one the block uses.
    always_comb begin
        key_d = ikey_we ? ikey : key_q;
`ifdef KLEIN_DEC_SCHED_CBC_EN
        pt_d  = icore_block ^ chain_q;
`else
        pt_d  = icore_block;
`endif
    end

    // Sequencer: accept, kick the core, wait (watchdogged), hold result until taken.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            state_q      <= IDLE;
            key_q        <= '0;
            cblk_q       <= '0;
            core_key_q   <= '0;
            out_block_q  <= '0;
            out_valid_q  <= 1'b0;
            core_start_q <= 1'b0;
            err_q        <= 1'b0;
            count_q      <= '0;
            wd_q         <= '0;
`ifdef KLEIN_DEC_SCHED_CBC_EN
            chain_q      <= '0;
`endif
        end else begin
            core_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    key_q <= key_d;
`ifdef KLEIN_DEC_SCHED_CBC_EN
                    if (iiv_we) begin
                        chain_q <= iiv;
                    end
`endif
                    if (iin_valid) begin
                        cblk_q       <= iin_block;
                        core_key_q   <= key_d;
                        core_start_q <= 1'b1;
                        state_q      <= START;
                    end
                end
                START: begin
                    wd_q    <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (icore_ready) begin
                        out_block_q <= pt_d;
                        out_valid_q <= 1'b1;
`ifdef KLEIN_DEC_SCHED_CBC_EN
                        chain_q     <= cblk_q;
`endif
                        state_q     <= OUT;
                    end else if (wd_q == WD_LIMIT) begin
                        err_q   <= 1'b1;
                        state_q <= HALT;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                OUT: begin
                    if (iout_ready) begin
                        out_valid_q <= 1'b0;
                        count_q     <= count_q + CNT_W'(1);
                        state_q     <= IDLE;
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign oin_ready   = (state_q == IDLE);
    assign obusy       = (state_q != IDLE);
    assign oout_valid  = out_valid_q;
    assign oout_block  = out_block_q;
    assign ocore_start = core_start_q;
    assign ocore_block = cblk_q;
    assign ocore_key   = core_key_q;
    assign oerr        = err_q;
    assign ocount      = count_q;

endmodule

// File: tb/tb_klein_dec_sched.sv
// tb/tb_klein_dec_sched.sv - scoreboard bench for klein_dec_sched with a 12-cycle core model
module tb_klein_dec_sched;

    localparam int TO = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          ireset = 1'b1;
    logic          ikey_we = 1'b0;
    logic [63:0]   ikey = '0;
    logic          iiv_we = 1'b0;
    logic [63:0]   iiv = '0;
    logic          iin_valid = 1'b0;
    logic [63:0]   iin_block = '0;
    logic          oin_ready;
    logic          oout_valid;
    logic [63:0]   oout_block;
    logic          iout_ready = 1'b1;
    logic          ocore_start;
    logic [63:0]   ocore_block;
    logic [63:0]   ocore_key;
    logic          icore_ready;
    logic [63:0]   icore_block;
    logic          obusy;
    logic          oerr;
    logic [CW-1:0] ocount;

    logic [63:0]   exp_q[$];
    int            n_checks = 0;
    int            n_fails = 0;

    logic          hang = 1'b0;
    int            ccnt = 0;
    logic          cready = 1'b0;
    logic [63:0]   cres = '0;

    always #5 clk = ~clk;

    klein_dec_sched #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
        .iclk(clk), .ireset(ireset),
        .ikey_we(ikey_we), .ikey(ikey), .iiv_we(iiv_we), .iiv(iiv),
        .iin_valid(iin_valid), .iin_block(iin_block), .oin_ready(oin_ready),
        .oout_valid(oout_valid), .oout_block(oout_block), .iout_ready(iout_ready),
        .ocore_start(ocore_start), .ocore_block(ocore_block), .ocore_key(ocore_key),
        .icore_ready(icore_ready), .icore_block(icore_block),
        .obusy(obusy), .oerr(oerr), .ocount(ocount)
    );

    // Core model: block ^ key, ready 12 cycles after start, ready cleared on start.
    always @(posedge clk) begin
        if (ocore_start) begin
            cready <= 1'b0;
            ccnt   <= 12;
            cres   <= ocore_block ^ ocore_key;
        end else if (ccnt > 0) begin
            ccnt <= ccnt - 1;
            if (ccnt == 1 && !hang) cready <= 1'b1;
        end
    end
    assign icore_ready = cready;
    assign icore_block = cres;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every downstream handshake pops and compares one expected block.
    always @(negedge clk) begin
        if (!ireset && oout_valid && iout_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_output: got %h expected none", oout_block);
            end else begin
                check("out_block", oout_block, exp_q.pop_front());
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ireset = 1'b1;
        step();
        ireset = 1'b0;
    endtask

    task automatic write_key(input logic [63:0] k);
        ikey = k; ikey_we = 1'b1;
        step();
        ikey_we = 1'b0;
    endtask

    task automatic write_iv(input logic [63:0] v);
        iiv = v; iiv_we = 1'b1;
        step();
        iiv_we = 1'b0;
    endtask

    // Returns just after the accepting edge (DUT is then in START).
    task automatic send(input logic [63:0] blk, input bit want, input logic [63:0] exp);
        int t = 0;
        iin_block = blk;
        iin_valid = 1'b1;
        while (!oin_ready && t < 200) begin
            step();
            t++;
        end
        check("accept_timeout", 64'(t >= 200), 64'd0);
        if (want) exp_q.push_back(exp);
        step();
        iin_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || oout_valid) && t < 300) begin
            step();
            t++;
        end
        check("drain_timeout", 64'(t >= 300), 64'd0);
    endtask

    logic [63:0] held;
    logic [CW-1:0] cnt0;
    int bad;

    initial begin
        step(2);
        do_reset();
        check("rst_in_ready", 64'(oin_ready), 64'd1);
        check("rst_out_valid", 64'(oout_valid), 64'd0);
        check("rst_busy", 64'(obusy), 64'd0);
        check("rst_err", 64'(oerr), 64'd0);
        check("rst_count", 64'(ocount), 64'd0);
        check("rst_core_start", 64'(ocore_start), 64'd0);
        check("rst_core_key", ocore_key, 64'd0);
        check("rst_out_block", oout_block, 64'd0);

`ifndef KLEIN_DEC_SCHED_CBC_EN
        // ECB basic
        write_key(64'h0123456789ABCDEF);
        send(64'hFFFFFFFFFFFFFFFF, 1'b1, 64'hFEDCBA9876543210);
        check("t1_core_start", 64'(ocore_start), 64'd1);
        check("t1_core_block", ocore_block, 64'hFFFFFFFFFFFFFFFF);
        check("t1_core_key", ocore_key, 64'h0123456789ABCDEF);
        step();
        check("t1_start_one_cycle", 64'(ocore_start), 64'd0);
        check("t1_busy", 64'(obusy), 64'd1);
        drain();
        check("t1_count", 64'(ocount), 64'd1);

        // Backpressure
        iout_ready = 1'b0;
        send(64'h0000000000000000, 1'b1, 64'h0123456789ABCDEF);
        bad = 0;
        while (!oout_valid && bad < 100) begin step(); bad++; end
        check("t3_valid_timeout", 64'(bad >= 100), 64'd0);
        held = oout_block;
        cnt0 = ocount;
        bad = 0;
        repeat (20) begin
            step();
            if (oout_block !== held || oout_valid !== 1'b1 || oin_ready !== 1'b0) bad++;
        end
        check("t3_stable_violations", 64'(bad), 64'd0);
        check("t3_held_block", held, 64'h0123456789ABCDEF);
        check("t3_count_held", 64'(ocount), 64'(cnt0));
        iout_ready = 1'b1;
        drain();
        check("t3_count_inc", 64'(ocount), 64'(cnt0) + 64'd1);

        // Key write while busy is ignored
        send(64'h1111111111111111, 1'b1, 64'h1032547698BADCFE);
        step(4);
        ikey = 64'hAAAAAAAAAAAAAAAA; ikey_we = 1'b1;
        step();
        ikey_we = 1'b0;
        check("t4_core_key_stable", ocore_key, 64'h0123456789ABCDEF);
        drain();
        send(64'h2222222222222222, 1'b1, 64'h23016745AB89EFCD);
        drain();
        write_key(64'hAAAAAAAAAAAAAAAA);
        send(64'h0000000000000000, 1'b1, 64'hAAAAAAAAAAAAAAAA);
        drain();
        // Key write coinciding with accept applies to that block
        ikey = 64'h5555555555555555; ikey_we = 1'b1;
        send(64'hFFFFFFFFFFFFFFFF, 1'b1, 64'hAAAAAAAAAAAAAAAA);
        ikey_we = 1'b0;
        drain();
        check("t4_count", 64'(ocount), 64'd6);
`else
        // CBC chaining from IV
        write_key(64'h0);
        write_iv(64'h1111111111111111);
        send(64'h2222222222222222, 1'b1, 64'h3333333333333333);
        drain();
        send(64'h4444444444444444, 1'b1, 64'h6666666666666666);
        drain();
        write_iv(64'h0);
        send(64'h1234567812345678, 1'b1, 64'h1234567812345678);
        drain();
        check("t2_count", 64'(ocount), 64'd3);
`endif

        // Hung core
        do_reset();
        write_key(64'h0123456789ABCDEF);
        hang = 1'b1;
        send(64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h0);
        step(1);
        step(TO - 1);
        check("t5_err_not_early", 64'(oerr), 64'd0);
        step(1);
        check("t5_err_set", 64'(oerr), 64'd1);
        check("t5_in_ready_low", 64'(oin_ready), 64'd0);
        check("t5_busy", 64'(obusy), 64'd1);
        step(5);
        check("t5_err_sticky", 64'(oerr), 64'd1);
        check("t5_halt_in_ready", 64'(oin_ready), 64'd0);
        check("t5_halt_out_valid", 64'(oout_valid), 64'd0);
        hang = 1'b0;
        do_reset();
        check("t5_err_cleared", 64'(oerr), 64'd0);
        check("t5_in_ready_back", 64'(oin_ready), 64'd1);
        write_key(64'h0123456789ABCDEF);
        send(64'hFFFFFFFFFFFFFFFF, 1'b1, 64'hFEDCBA9876543210);
        drain();
        check("t5_count", 64'(ocount), 64'd1);

        // Reset while waiting on the core
        send(64'h0000000000000000, 1'b0, 64'h0);
        step(5);
        do_reset();
        check("t6_out_valid", 64'(oout_valid), 64'd0);
        check("t6_count", 64'(ocount), 64'd0);
        check("t6_busy", 64'(obusy), 64'd0);
        bad = 0;
        repeat (20) begin
            step();
            if (oout_valid !== 1'b0) bad++;
        end
        check("t6_no_output", 64'(bad), 64'd0);
        write_key(64'h0123456789ABCDEF);
        send(64'hFFFFFFFFFFFFFFFF, 1'b1, 64'hFEDCBA9876543210);
        drain();
        check("t6_count_after", 64'(ocount), 64'd1);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
